// File: rtl/frv_mtime_access_if.sv
// Request/response and MMIO signal bundle for frv_mtime_access.
// master: the access engine; slave: the CSR/LSU side plus the timer block.
interface frv_mtime_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic        mmio_en;
    logic        mmio_wen;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        mmio_error;

    modport master (
        input  req_valid, req_op, req_wdata, rsp_ready, mmio_rdata, mmio_error,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
               mmio_en, mmio_wen, mmio_addr, mmio_wdata
    );

    modport slave (
        output req_valid, req_op, req_wdata, rsp_ready, mmio_rdata, mmio_error,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
               mmio_en, mmio_wen, mmio_addr, mmio_wdata
    );
endinterface

// File: rtl/frv_mtime_access.sv
// Atomic 64-bit mtime read / mtimecmp write over a 32-bit MMIO port.
// FRV_MTIMECMP_SAFE_WRITE_EN: write lo=all-ones first so mtimecmp never dips mid-update.
module frv_mtime_access #(
    parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_1000,
    parameter int unsigned MAX_RETRY      = 4
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    frv_mtime_access_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE, RD_HI0, RD_LO, RD_HI1, WR_LO_MAX, WR_HI, WR_LO, RESP
    } state_t;

`ifdef FRV_MTIMECMP_SAFE_WRITE_EN
    localparam state_t WR_FIRST = WR_LO_MAX;
`else
    localparam state_t WR_FIRST = WR_HI;
`endif

    localparam int unsigned RW = $clog2(MAX_RETRY + 1);

    state_t        state_q, state_d;
    logic          phase_q, phase_d;   // 0 = ISSUE, 1 = SAMPLE
    logic [31:0]   h0_q, h0_d;
    logic [31:0]   lo_q, lo_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          error_q, error_d;
    logic [RW-1:0] retry_q, retry_d;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            h0_q    <= '0;
            lo_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            h0_q    <= h0_d;
            lo_q    <= lo_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        h0_d    = h0_q;
        lo_d    = lo_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        retry_d = retry_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    phase_d = 1'b0;
                    retry_d = '0;
                    error_d = 1'b0;
                    rdata_d = '0;
                    wdata_d = bus.req_wdata;
                    state_d = bus.req_op ? WR_FIRST : RD_HI0;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (bus.mmio_error) begin
                        state_d = RESP;
                        error_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        case (state_q)
                            RD_HI0: begin
                                h0_d    = bus.mmio_rdata;
                                state_d = RD_LO;
                            end
                            RD_LO: begin
                                lo_d    = bus.mmio_rdata;
                                state_d = RD_HI1;
                            end
                            RD_HI1: begin
                                // Mismatch means lo wrapped between hi reads; re-read lo against the new hi.
                                if (bus.mmio_rdata == h0_q) begin
                                    state_d = RESP;
                                    rdata_d = {bus.mmio_rdata, lo_q};
                                end else if (retry_q == RW'(MAX_RETRY)) begin
                                    state_d = RESP;
                                    error_d = 1'b1;
                                    rdata_d = {bus.mmio_rdata, lo_q};
                                end else begin
                                    h0_d    = bus.mmio_rdata;
                                    retry_d = retry_q + RW'(1);
                                    state_d = RD_LO;
                                end
                            end
                            WR_LO_MAX: state_d = WR_HI;
                            WR_HI:     state_d = WR_LO;
                            WR_LO:     state_d = RESP;
                            default:   state_d = IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        logic issue;
        issue          = (state_q != IDLE) && (state_q != RESP) && !phase_q;
        bus.req_ready  = (state_q == IDLE);
        bus.rsp_valid  = (state_q == RESP);
        bus.rsp_rdata  = rdata_q;
        bus.rsp_error  = error_q;
        bus.mmio_en    = issue;
        bus.mmio_wen   = 1'b0;
        bus.mmio_addr  = '0;
        bus.mmio_wdata = '0;
        if (issue) begin
            case (state_q)
                RD_HI0, RD_HI1: bus.mmio_addr = MMIO_BASE_ADDR + 32'h4;
                RD_LO:          bus.mmio_addr = MMIO_BASE_ADDR;
                WR_LO_MAX: begin
                    bus.mmio_wen   = 1'b1;
                    bus.mmio_addr  = MMIO_BASE_ADDR + 32'h8;
                    bus.mmio_wdata = '1;
                end
                WR_HI: begin
                    bus.mmio_wen   = 1'b1;
                    bus.mmio_addr  = MMIO_BASE_ADDR + 32'hC;
                    bus.mmio_wdata = wdata_q[63:32];
                end
                WR_LO: begin
                    bus.mmio_wen   = 1'b1;
                    bus.mmio_addr  = MMIO_BASE_ADDR + 32'h8;
                    bus.mmio_wdata = wdata_q[31:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frv_mtime_access.sv
// Scoreboard bench for frv_mtime_access: directed requests, timer-block model, queue-based checking.
module tb_frv_mtime_access;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        int unsigned off;
    } mmio_exp_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int unsigned lat;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frv_mtime_access_if bus ();

    frv_mtime_access #(
        .MMIO_BASE_ADDR (32'h0000_1000),
        .MAX_RETRY      (4)
    ) dut (
        .g_clk   (clk),
        .g_reset (rst),
        .bus     (bus)
    );

    mmio_exp_t   mq[$];
    rsp_exp_t    rq[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned hs_cyc = 0;
    logic [63:0] mt_base = '0;
    int unsigned mt_cyc = 0;
    int unsigned err_lo_cyc = 32'hFFFF_FFFF;
    int          mode = 0;
    logic [31:0] hi_cnt = 32'h0000_0100;
    logic [63:0] mt_now;

    assign mt_now = mt_base + 64'(cyc - mt_cyc);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Timer block: read data/error valid the cycle after the strobe; mtime advances once per cycle.
    always @(posedge clk) begin
        bus.mmio_rdata <= '0;
        bus.mmio_error <= 1'b0;
        if (bus.mmio_en && !bus.mmio_wen) begin
            if (bus.mmio_addr == 32'h0000_1004) begin
                if (mode == 1) begin
                    bus.mmio_rdata <= hi_cnt;
                    hi_cnt         <= hi_cnt + 32'd1;
                end else begin
                    bus.mmio_rdata <= mt_now[63:32];
                end
            end else begin
                bus.mmio_rdata <= (mode == 1) ? 32'h0000_AAAA : mt_now[31:0];
            end
        end
        if (bus.mmio_en && bus.mmio_addr == 32'h0000_1000 && cyc == err_lo_cyc)
            bus.mmio_error <= 1'b1;
        cyc <= cyc + 1;
    end

    mmio_exp_t   me;
    rsp_exp_t    re;
    logic        prev_rv = 1'b0;
    logic [63:0] hold_rdata = '0;
    logic        hold_err = 1'b0;

    always @(negedge clk) begin
        if (bus.req_valid && bus.req_ready) hs_cyc = cyc;
        if (bus.mmio_en) begin
            if (mq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_mmio: got addr %h wen %b, expected no access", bus.mmio_addr, bus.mmio_wen);
            end else begin
                me = mq.pop_front();
                check("mmio_addr", 64'(bus.mmio_addr), 64'(me.addr));
                check("mmio_wen", 64'(bus.mmio_wen), 64'(me.wen));
                if (me.wen) check("mmio_wdata", 64'(bus.mmio_wdata), 64'(me.wdata));
                check("mmio_offset", 64'(cyc - hs_cyc), 64'(me.off));
            end
        end
        if (bus.rsp_valid) begin
            check("req_ready_in_resp", 64'(bus.req_ready), 64'(0));
            if (!prev_rv) begin
                if (rq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got rdata %h, expected no response", bus.rsp_rdata);
                end else begin
                    re = rq.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, re.rdata);
                    check("rsp_error", 64'(bus.rsp_error), 64'(re.err));
                    check("rsp_latency", 64'(cyc - hs_cyc), 64'(re.lat));
                end
            end else begin
                check("rsp_rdata_stable", bus.rsp_rdata, hold_rdata);
                check("rsp_error_stable", 64'(bus.rsp_error), 64'(hold_err));
            end
            hold_rdata = bus.rsp_rdata;
            hold_err   = bus.rsp_error;
        end
        prev_rv = bus.rsp_valid;
    end

    task automatic push_m(input logic [31:0] addr, input logic wen, input logic [31:0] wd, input int unsigned off);
        mmio_exp_t e;
        e.addr = addr; e.wen = wen; e.wdata = wd; e.off = off;
        mq.push_back(e);
    endtask

    task automatic push_r(input logic [63:0] rd, input logic err, input int unsigned lat);
        rsp_exp_t e;
        e.rdata = rd; e.err = err; e.lat = lat;
        rq.push_back(e);
    endtask

    task automatic send(input logic op, input logic [63:0] wd, output int unsigned hs);
        bit got;
        got = 1'b0;
        hs  = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_wdata = wd;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                got = 1'b1;
                hs  = cyc;
                break;
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL req_accept_timeout: got req_ready 0 for 50 cycles, expected 1");
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL rsp_timeout: got no response in 100 cycles, expected one");
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
        check({tag, "_rsp_error"}, 64'(bus.rsp_error), 64'(0));
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 64'h0);
        check({tag, "_mmio_en"}, 64'(bus.mmio_en), 64'(0));
        check({tag, "_mmio_wen"}, 64'(bus.mmio_wen), 64'(0));
        check({tag, "_mmio_addr"}, 64'(bus.mmio_addr), 64'h0);
        check({tag, "_mmio_wdata"}, 64'(bus.mmio_wdata), 64'h0);
    endtask

    initial begin
        int unsigned hs;
        logic [31:0] cnt0;
        bit          got;
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Plain read, no hi change
        push_m(32'h1004, 1'b0, 32'h0, 1);
        push_m(32'h1000, 1'b0, 32'h0, 3);
        push_m(32'h1004, 1'b0, 32'h0, 5);
        push_r(64'h0000_0005_0000_0012, 1'b0, 7);
        send(1'b0, 64'h0, hs);
        mt_base = 64'h0000_0005_0000_0010; mt_cyc = hs + 1;
        wait_rsp();

        // lo wraps between hi reads: one retry
        push_m(32'h1004, 1'b0, 32'h0, 1);
        push_m(32'h1000, 1'b0, 32'h0, 3);
        push_m(32'h1004, 1'b0, 32'h0, 5);
        push_m(32'h1000, 1'b0, 32'h0, 7);
        push_m(32'h1004, 1'b0, 32'h0, 9);
        push_r(64'h0000_0003_0000_0003, 1'b0, 11);
        send(1'b0, 64'h0, hs);
        mt_base = 64'h0000_0002_FFFF_FFFD; mt_cyc = hs + 1;
        wait_rsp();

        // mtimecmp write
`ifdef FRV_MTIMECMP_SAFE_WRITE_EN
        push_m(32'h1008, 1'b1, 32'hFFFF_FFFF, 1);
        push_m(32'h100C, 1'b1, 32'h1234_5678, 3);
        push_m(32'h1008, 1'b1, 32'h9ABC_DEF0, 5);
        push_r(64'h0, 1'b0, 7);
`else
        push_m(32'h100C, 1'b1, 32'h1234_5678, 1);
        push_m(32'h1008, 1'b1, 32'h9ABC_DEF0, 3);
        push_r(64'h0, 1'b0, 5);
`endif
        send(1'b1, 64'h1234_5678_9ABC_DEF0, hs);
        wait_rsp();

        // MMIO error on the lo sample aborts the read
        push_m(32'h1004, 1'b0, 32'h0, 1);
        push_m(32'h1000, 1'b0, 32'h0, 3);
        push_r(64'h0, 1'b1, 5);
        send(1'b0, 64'h0, hs);
        mt_base = 64'h0000_0007_0000_0000; mt_cyc = hs + 1;
        err_lo_cyc = hs + 3;
        wait_rsp();
        err_lo_cyc = 32'hFFFF_FFFF;

        // Response back-pressure with a competing request held high
        push_m(32'h1004, 1'b0, 32'h0, 1);
        push_m(32'h1000, 1'b0, 32'h0, 3);
        push_m(32'h1004, 1'b0, 32'h0, 5);
        push_r(64'h0000_00AB_0000_0102, 1'b0, 7);
        bus.rsp_ready = 1'b0;
        send(1'b0, 64'h0, hs);
        mt_base = 64'h0000_00AB_0000_0100; mt_cyc = hs + 1;
        bus.req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL hold_rsp_timeout: got rsp_valid 0 for 50 cycles, expected 1");
        end
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after_rsp_req_ready", 64'(bus.req_ready), 64'(1));
        check("idle_after_rsp_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        @(posedge clk); #1;

        // Reset during the WR_HI issue cycle
`ifdef FRV_MTIMECMP_SAFE_WRITE_EN
        push_m(32'h1008, 1'b1, 32'hFFFF_FFFF, 1);
        push_m(32'h100C, 1'b1, 32'hCAFE_0001, 3);
`else
        push_m(32'h100C, 1'b1, 32'hCAFE_0001, 1);
`endif
        send(1'b1, 64'hCAFE_0001_0000_0002, hs);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mmio_en && bus.mmio_addr == 32'h100C) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL wr_hi_not_seen: got no 0x100C access in 20 cycles, expected one");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Read after the abandoned write
        push_m(32'h1004, 1'b0, 32'h0, 1);
        push_m(32'h1000, 1'b0, 32'h0, 3);
        push_m(32'h1004, 1'b0, 32'h0, 5);
        push_r(64'h0000_0001_2345_0002, 1'b0, 7);
        send(1'b0, 64'h0, hs);
        mt_base = 64'h0000_0001_2345_0000; mt_cyc = hs + 1;
        wait_rsp();

        // hi changes on every read: 4 retries then error on the 5th mismatch
        mode = 1;
        cnt0 = hi_cnt;
        push_m(32'h1004, 1'b0, 32'h0, 1);
        push_m(32'h1000, 1'b0, 32'h0, 3);
        push_m(32'h1004, 1'b0, 32'h0, 5);
        for (int unsigned k = 0; k < 4; k++) begin
            push_m(32'h1000, 1'b0, 32'h0, 7 + 4 * k);
            push_m(32'h1004, 1'b0, 32'h0, 9 + 4 * k);
        end
        push_r({cnt0 + 32'd5, 32'h0000_AAAA}, 1'b1, 23);
        send(1'b0, 64'h0, hs);
        wait_rsp();
        mode = 0;

        repeat (3) @(negedge clk);
        check("mmio_queue_drained", 64'(mq.size()), 64'(0));
        check("rsp_queue_drained", 64'(rq.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 time units, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
